// File: rtl/fetch_realigner.sv
// Fetch realigner: requests aligned words, buffers halfwords, emits one aligned instruction per handshake.
// Define FETCH_RVC_EN to enable 16-bit RVC instructions; otherwise every instruction is 32-bit.
//   state     | meaning
//   F_IDLE    | no request outstanding; issue one when buffer has room
//   F_WAIT    | request outstanding; response is appended to the buffer
//   F_DISCARD | request outstanding but flushed by a redirect; response dropped
module fetch_realigner #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_compflg
);

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_WAIT    = 2'd1,
        F_DISCARD = 2'd2
    } fstate_t;

    fstate_t     state_q, state_d;
    logic        fetch_req_q, fetch_req_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] hw_q [4];
    logic [15:0] hw_d [4];
    logic        drop_low_q, drop_low_d;

    logic        is_rvc;
    logic        avail;
    logic        consume;
    logic        accept;
    logic [2:0]  n_cons;
    logic [2:0]  n_app;
    logic [2:0]  cnt_mid;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Output view is a pure function of registered buffer state, so it holds while stalled.
    always_comb begin
`ifdef FETCH_RVC_EN
        is_rvc = (hw_q[0][1:0] != 2'b11);
        avail  = is_rvc ? (cnt_q >= 3'd1) : (cnt_q >= 3'd2);
`else
        is_rvc = 1'b0;
        avail  = (cnt_q >= 3'd2);
`endif
        out_valid   = avail;
        out_compflg = avail & is_rvc;
        out_pc      = pc_q;
        if (!avail)
            out_instr = 32'h0;
        else if (is_rvc)
            out_instr = {16'h0000, hw_q[0]};
        else
            out_instr = {hw_q[1], hw_q[0]};
    end

    assign fetch_req  = fetch_req_q;
    assign fetch_addr = fetch_addr_q;

    always_comb begin
        consume = avail && out_ready && !redirect;
        n_cons  = consume ? (is_rvc ? 3'd1 : 3'd2) : 3'd0;
        accept  = (state_q == F_WAIT) && fetch_valid && !redirect;
        n_app   = accept ? (drop_low_q ? 3'd1 : 3'd2) : 3'd0;
        cnt_mid = cnt_q - n_cons;

        hw_d = hw_q;
        case (n_cons)
            3'd1: begin
                for (int i = 0; i < 3; i++) hw_d[i] = hw_q[i+1];
                hw_d[3] = '0;
            end
            3'd2: begin
                hw_d[0] = hw_q[2];
                hw_d[1] = hw_q[3];
                hw_d[2] = '0;
                hw_d[3] = '0;
            end
            default: ;
        endcase

        // New halfwords land directly behind whatever survives this cycle's consume.
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (drop_low_q) begin
                    if (3'(i) == cnt_mid) hw_d[i] = fetch_data[31:16];
                end else begin
                    if (3'(i) == cnt_mid)
                        hw_d[i] = fetch_data[15:0];
                    else if (3'(i) == cnt_mid + 3'd1)
                        hw_d[i] = fetch_data[31:16];
                end
            end
        end

        cnt_d = cnt_mid + n_app;
        if (redirect) cnt_d = 3'd0;
    end

    always_comb begin
        state_d      = state_q;
        fetch_req_d  = 1'b0;
        fetch_addr_d = fetch_req_q ? (fetch_addr_q + 32'd4) : fetch_addr_q;
        drop_low_d   = drop_low_q;
        pc_d         = pc_q;

        case (state_q)
            F_IDLE: begin
                if (!redirect && cnt_q <= 3'd2) begin
                    state_d     = F_WAIT;
                    fetch_req_d = 1'b1;
                end
            end
            F_WAIT: begin
                if (fetch_valid) begin
                    state_d = F_IDLE;
                    if (accept) drop_low_d = 1'b0;
                end else if (redirect) begin
                    state_d = F_DISCARD;
                end
            end
            F_DISCARD: begin
                if (fetch_valid) state_d = F_IDLE;
            end
            default: state_d = F_IDLE;
        endcase

        if (consume) pc_d = pc_q + (is_rvc ? 32'd2 : 32'd4);

        if (redirect) begin
            fetch_addr_d = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_RVC_EN
            pc_d       = {redirect_pc[31:1], 1'b0};
            drop_low_d = redirect_pc[1];
`else
            pc_d       = {redirect_pc[31:2], 2'b00};
            drop_low_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= F_IDLE;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= PC_RESET;
            pc_q         <= PC_RESET;
            cnt_q        <= 3'd0;
            hw_q         <= '{default: '0};
            drop_low_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            hw_q         <= hw_d;
            drop_low_q   <= drop_low_d;
        end
    end

endmodule

// File: tb/tb_fetch_realigner.sv
// Directed bench for fetch_realigner: instruction-stream vector table plus hand-written
// sequences for stall, redirect-with-pending-fetch, redirect-vs-ready and async reset.
module tb_fetch_realigner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_compflg;

    always #5 clk = ~clk;

    fetch_realigner #(.PC_RESET(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_compflg(out_compflg)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] mem [16];
    int          mem_lat = 1;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!fetch_req && n < 30) begin
            step();
            n++;
        end
        check(name, 32'(fetch_req), 32'd1);
    endtask

    // Memory model: returns mem[addr] mem_lat cycles after each request; flushed by reset.
    initial begin
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        pend_cnt    = 0;
        pend_addr   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            fetch_valid = 1'b0;
            if (!reset_n) begin
                pend_cnt = 0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        fetch_valid = 1'b1;
                        fetch_data  = mem[pend_addr[5:2]];
                    end
                end
                if (fetch_req) begin
                    pend_addr = fetch_addr;
                    pend_cnt  = mem_lat;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          req_cnt;
        logic        stable, seen;
        logic [31:0] s_pc, s_instr;
        logic        s_comp;

        mem[0] = 32'h0001_0513;
        mem[1] = 32'h4505_4501;
        mem[2] = 32'h0513_4501;
        mem[3] = 32'h4501_0001;
        mem[4] = 32'h0020_0593;
        mem[5] = 32'h0030_0613;
        for (int i = 6; i < 16; i++) mem[i] = {12'(i), 20'h00013};

`ifdef FETCH_RVC_EN
        vecs[0] = '{32'h00, 32'h0001_0513, 1'b0};
        vecs[1] = '{32'h04, 32'h0000_4501, 1'b1};
        vecs[2] = '{32'h06, 32'h0000_4505, 1'b1};
        vecs[3] = '{32'h08, 32'h0000_4501, 1'b1};
        vecs[4] = '{32'h0A, 32'h0001_0513, 1'b0};
        vecs[5] = '{32'h0E, 32'h0000_4501, 1'b1};
        vecs[6] = '{32'h10, 32'h0020_0593, 1'b0};
        vecs[7] = '{32'h14, 32'h0030_0613, 1'b0};
`else
        vecs[0] = '{32'h00, 32'h0001_0513, 1'b0};
        vecs[1] = '{32'h04, 32'h4505_4501, 1'b0};
        vecs[2] = '{32'h08, 32'h0513_4501, 1'b0};
        vecs[3] = '{32'h0C, 32'h4501_0001, 1'b0};
        vecs[4] = '{32'h10, 32'h0020_0593, 1'b0};
        vecs[5] = '{32'h14, 32'h0030_0613, 1'b0};
        vecs[6] = '{32'h18, 32'h0060_0013, 1'b0};
        vecs[7] = '{32'h1C, 32'h0070_0013, 1'b0};
`endif

        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;

        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_instr", out_instr, 32'h0);
        check("rst out_compflg", 32'(out_compflg), 32'd0);
        check("rst out_pc", out_pc, 32'h0);
        check("rst fetch_req", 32'(fetch_req), 32'd0);
        check("rst fetch_addr", fetch_addr, 32'h0);

        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        check("first req", 32'(fetch_req), 32'd1);
        check("first addr", fetch_addr, 32'h0);
        step();
        check("req pulse ends", 32'(fetch_req), 32'd0);
        check("addr after req", fetch_addr, 32'h4);
        check("no valid before data", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_valid("vec valid");
            check("vec pc", out_pc, vecs[k].pc);
            check("vec instr", out_instr, vecs[k].instr);
            check("vec compflg", 32'(out_compflg), 32'(vecs[k].comp));
            step();
        end

        // Stall: buffer fills to 4 halfwords, outputs frozen, exactly two requests.
        out_ready = 1'b0;
        pulse_redirect(32'h20);
        check("stall empty after redirect", 32'(out_valid), 32'd0);
        req_cnt = 0;
        stable  = 1'b1;
        seen    = 1'b0;
        s_pc    = 32'h0;
        s_instr = 32'h0;
        s_comp  = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (fetch_req) req_cnt++;
            if (out_valid) begin
                if (!seen) begin
                    seen    = 1'b1;
                    s_pc    = out_pc;
                    s_instr = out_instr;
                    s_comp  = out_compflg;
                end else if (out_pc !== s_pc || out_instr !== s_instr || out_compflg !== s_comp) begin
                    stable = 1'b0;
                end
            end
            step();
        end
        check("stall req count", 32'(req_cnt), 32'd2);
        check("stall stable", 32'(stable & seen), 32'd1);
        check("stall pc", out_pc, 32'h20);
        check("stall instr", out_instr, mem[8]);
        check("stall no req", 32'(fetch_req), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after stall valid", 32'(out_valid), 32'd1);
        check("after stall pc", out_pc, 32'h24);
        check("after stall instr", out_instr, mem[9]);

        // Redirect to 0x102 while a fetch for 0x30 is outstanding.
        out_ready = 1'b1;
        mem_lat   = 4;
        pulse_redirect(32'h30);
        wait_req("pend req seen");
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        check("redir fetch_addr", fetch_addr, 32'h100);
        check("redir valid low", 32'(out_valid), 32'd0);
        wait_valid("redir valid");
`ifdef FETCH_RVC_EN
        check("redir pc", out_pc, 32'h102);
        check("redir instr", out_instr, 32'h0000_0001);
        check("redir compflg", 32'(out_compflg), 32'd1);
`else
        check("redir pc", out_pc, 32'h100);
        check("redir instr", out_instr, 32'h0001_0513);
        check("redir compflg", 32'(out_compflg), 32'd0);
`endif
        step();
        wait_valid("redir next valid");
        check("redir next pc", out_pc, 32'h104);
`ifdef FETCH_RVC_EN
        check("redir next instr", out_instr, 32'h0000_4501);
`else
        check("redir next instr", out_instr, 32'h4505_4501);
`endif

        // Redirect and out_ready in the same cycle: the redirect wins.
        mem_lat   = 1;
        out_ready = 1'b0;
        wait_valid("rr valid");
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        out_ready   = 1'b1;
        step();
        redirect  = 1'b0;
        out_ready = 1'b0;
        check("rr valid cleared", 32'(out_valid), 32'd0);
        check("rr pc", out_pc, 32'h8);
        out_ready = 1'b1;
        wait_valid("rr refill valid");
        check("rr refill pc", out_pc, 32'h8);
`ifdef FETCH_RVC_EN
        check("rr refill instr", out_instr, 32'h0000_4501);
        check("rr refill compflg", 32'(out_compflg), 32'd1);
`else
        check("rr refill instr", out_instr, 32'h0513_4501);
        check("rr refill compflg", 32'(out_compflg), 32'd0);
`endif

        // Async reset asserted while a request is outstanding.
        mem_lat = 4;
        pulse_redirect(32'h10);
        wait_req("mid req seen");
        step();
        check("mid pre-reset addr", fetch_addr, 32'h14);
        check("mid pre-reset pc", out_pc, 32'h10);
        #1 reset_n = 1'b0;
        #1;
        check("mid rst fetch_req", 32'(fetch_req), 32'd0);
        check("mid rst fetch_addr", fetch_addr, 32'h0);
        check("mid rst out_pc", out_pc, 32'h0);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst out_instr", out_instr, 32'h0);
        check("mid rst out_compflg", 32'(out_compflg), 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        wait_valid("post rst valid");
        check("post rst pc", out_pc, 32'h0);
        check("post rst instr", out_instr, 32'h0001_0513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
